video_pattern_generator: RTL

Parametrised raster timing and test-pattern source: replaces the fixed 640x480 single-pattern generator with full porch/sync timing, selectable background patterns, a multi-bit pixel and a configurable bouncing square. It sits between the pixel-clock domain logic and the video output encoder/PHY. All outputs are registered and mutually aligned. Every state update is qualified by a clock enable, which gives pixel-rate stepping.

---
 rtl/video_pattern_generator.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/video_pattern_generator.sv
// Raster timing and test-pattern source: porch/sync timing, selectable background
// patterns and a bouncing square overlay, all outputs registered and aligned.
module video_pattern_generator #(
  parameter int unsigned NumColActive = 640,
  parameter int unsigned HFrontPorch  = 16,
  parameter int unsigned HSyncLen     = 96,
  parameter int unsigned HBackPorch   = 48,
  parameter int unsigned NumRowActive = 480,
  parameter int unsigned VFrontPorch  = 10,
  parameter int unsigned VSyncLen     = 2,
  parameter int unsigned VBackPorch   = 33,
  parameter logic        HSyncPol     = 1'b0,
  parameter logic        VSyncPol     = 1'b0,
  parameter int unsigned PixWidth     = 4,
  parameter int unsigned SquareSize   = 32,
  parameter int unsigned SquareStep   = 2,
  parameter int unsigned BarShift     = 7,
  parameter int unsigned CheckShift   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ce_i,
  input  logic [1:0]          mode_i,
  input  logic                sq_en_i,
  output logic                de_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic [PixWidth-1:0] pix_o,
  output logic                sof_o,
  output logic [15:0]         frame_o
);

  localparam int unsigned ColTotal = NumColActive + HFrontPorch + HSyncLen + HBackPorch;
  localparam int unsigned RowTotal = NumRowActive + VFrontPorch + VSyncLen + VBackPorch;
  localparam int unsigned ColW     = $clog2(ColTotal);
  localparam int unsigned RowW     = $clog2(RowTotal);
  localparam int unsigned XMax     = NumColActive - SquareSize;
  localparam int unsigned YMax     = NumRowActive - SquareSize;
  localparam int unsigned HsStart  = NumColActive + HFrontPorch;
  localparam int unsigned VsStart  = NumRowActive + VFrontPorch;

  logic [ColW-1:0]     col_q, col_d, sx_q, sx_d;
  logic [RowW-1:0]     row_q, row_d, sy_q, sy_d;
  logic                dirx_q, dirx_d, diry_q, diry_d;
  logic [1:0]          mode_q, mode_d;
  logic                sq_en_q, sq_en_d;
  logic [15:0]         frame_q, frame_d;
  logic                de_q, de_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d;
  logic [PixWidth-1:0] pix_q, pix_d;

  logic [31:0] col_w, row_w, sx_w, sy_w;
  logic        col_last, row_last, frame_end, active, in_sq;

  always_comb begin
    col_w     = 32'(col_q);
    row_w     = 32'(row_q);
    sx_w      = 32'(sx_q);
    sy_w      = 32'(sy_q);
    col_last  = (col_w == ColTotal - 1);
    row_last  = (row_w == RowTotal - 1);
    frame_end = col_last && row_last;

    col_d   = col_last ? '0 : col_q + 1'b1;
    row_d   = row_q;
    if (col_last) row_d = row_last ? '0 : row_q + 1'b1;

    sx_d    = sx_q;
    sy_d    = sy_q;
    dirx_d  = dirx_q;
    diry_d  = diry_q;
    mode_d  = mode_q;
    sq_en_d = sq_en_q;
    frame_d = frame_q;
    if (frame_end) begin
      mode_d  = mode_i;
      sq_en_d = sq_en_i;
      frame_d = frame_q + 16'd1;
      // Each axis clamps at its limit and reverses on the same frame.
      if (!dirx_q) begin
        if (sx_w + SquareStep >= XMax) begin
          sx_d   = ColW'(XMax);
          dirx_d = 1'b1;
        end else begin
          sx_d = ColW'(sx_w + SquareStep);
        end
      end else if (sx_w <= SquareStep) begin
        sx_d   = '0;
        dirx_d = 1'b0;
      end else begin
        sx_d = ColW'(sx_w - SquareStep);
      end
      if (!diry_q) begin
        if (sy_w + SquareStep >= YMax) begin
          sy_d   = RowW'(YMax);
          diry_d = 1'b1;
        end else begin
          sy_d = RowW'(sy_w + SquareStep);
        end
      end else if (sy_w <= SquareStep) begin
        sy_d   = '0;
        diry_d = 1'b0;
      end else begin
        sy_d = RowW'(sy_w - SquareStep);
      end
    end

    active = (col_w < NumColActive) && (row_w < NumRowActive);
    in_sq  = (col_w >= sx_w) && (col_w < sx_w + SquareSize) &&
             (row_w >= sy_w) && (row_w < sy_w + SquareSize);
    de_d   = active;
    hs_d   = ((col_w >= HsStart) && (col_w < HsStart + HSyncLen)) ? HSyncPol : ~HSyncPol;
    vs_d   = ((row_w >= VsStart) && (row_w < VsStart + VSyncLen)) ? VSyncPol : ~VSyncPol;
    sof_d  = (col_w == 0) && (row_w == 0);

    pix_d = '0;
    unique case (mode_q)
      2'd0: pix_d = PixWidth'(col_w >> BarShift);
      2'd1: pix_d = {PixWidth{col_w[CheckShift] ^ row_w[CheckShift]}};
      2'd2: pix_d = {PixWidth{|(col_w & row_w)}};
      default: pix_d = '0;
    endcase
    if (sq_en_q && in_sq) pix_d = '1;
    if (!active)          pix_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q   <= '0;
      row_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      dirx_q  <= 1'b0;
      diry_q  <= 1'b0;
      mode_q  <= '0;
      sq_en_q <= 1'b0;
      frame_q <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HSyncPol;
      vs_q    <= ~VSyncPol;
      sof_q   <= 1'b0;
      pix_q   <= '0;
    end else if (ce_i) begin
      col_q   <= col_d;
      row_q   <= row_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      dirx_q  <= dirx_d;
      diry_q  <= diry_d;
      mode_q  <= mode_d;
      sq_en_q <= sq_en_d;
      frame_q <= frame_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      sof_q   <= sof_d;
      pix_q   <= pix_d;
    end
  end

  assign de_o    = de_q;
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;
  assign sof_o   = sof_q;
  assign pix_o   = pix_q;
  assign frame_o = frame_q;

endmodule
